// File: rtl/nv_pipe_skid_x_pkg.sv
// Shared vlibs encoding for the skid pipe stage: occupancy state values and
// small helpers used to derive the registered control outputs from a state.
package nv_pipe_skid_x_pkg;

   typedef logic [1:0] skid_state_t;

   localparam skid_state_t ST_EMPTY = 2'd0;
   localparam skid_state_t ST_ONE   = 2'd1;
   localparam skid_state_t ST_FULL  = 2'd2;

   function automatic logic state_has_main(input skid_state_t st);
      return (st == ST_ONE) || (st == ST_FULL);
   endfunction

   function automatic logic state_has_skid(input skid_state_t st);
      return (st == ST_FULL);
   endfunction

   // The stage can take a word whenever the skid slot is free.
   function automatic logic state_can_accept(input skid_state_t st);
      return (st != ST_FULL);
   endfunction

endpackage

// File: rtl/nv_pipe_skid_x_reg.sv
// DW-wide load-enable register with asynchronous reset to RESET_PD.
module nv_pipe_reg_x #(
   parameter int             DW       = 32,
   parameter logic [DW-1:0]  RESET_PD = '0
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          en,
   input  logic [DW-1:0] d,
   output logic [DW-1:0] q
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q <= RESET_PD;
      end else if (en) begin
         q <= d;
      end
   end

endmodule

// File: rtl/nv_pipe_skid_x.sv
// Registered valid/ready pipe stage with a one-entry skid buffer; every
// output (in_rdy, out_vld, out_pd, occ) comes straight from a flop.
module nv_pipe_skid_x
   import nv_pipe_skid_x_pkg::*;
#(
   parameter int             DW       = 32,
   parameter logic [DW-1:0]  RESET_PD = '0
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          in_vld,
   output logic          in_rdy,
   input  logic [DW-1:0] in_pd,
   output logic          out_vld,
   input  logic          out_rdy,
   output logic [DW-1:0] out_pd,
   output logic [1:0]    occ
);

   skid_state_t   st_q;
   skid_state_t   st_n;
   logic          skid_vld;
   logic          in_xfer;
   logic          out_xfer;
   logic          main_en;
   logic          main_from_skid;
   logic          skid_en;
   logic [DW-1:0] main_d;
   logic [DW-1:0] skid_pd;

   assign in_xfer  = in_vld & in_rdy;
   assign out_xfer = out_vld & out_rdy;

   always_comb begin
      st_n           = st_q;
      main_en        = 1'b0;
      main_from_skid = 1'b0;
      skid_en        = 1'b0;
      case (st_q)
         ST_EMPTY: begin
            if (in_xfer) begin
               st_n    = ST_ONE;
               main_en = 1'b1;
            end
         end
         ST_ONE: begin
            if (in_xfer && out_xfer) begin
               main_en = 1'b1;
            end else if (in_xfer) begin
               st_n    = ST_FULL;
               skid_en = 1'b1;
            end else if (out_xfer) begin
               st_n    = ST_EMPTY;
            end
         end
         ST_FULL: begin
            // in_rdy is low here, so only the drain of main can happen.
            if (out_xfer) begin
               st_n           = ST_ONE;
               main_en        = 1'b1;
               main_from_skid = 1'b1;
            end
         end
         default: begin
            st_n = ST_EMPTY;
         end
      endcase
   end

   // Payload is only loaded on a real transfer, so an undriven in_pd while
   // in_vld=0 and a stale skid_pd while skid_vld=0 never reach out_pd.
   assign main_d = main_from_skid ? skid_pd : in_pd;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         st_q     <= ST_EMPTY;
         out_vld  <= 1'b0;
         skid_vld <= 1'b0;
         in_rdy   <= 1'b1;
      end else begin
         st_q     <= st_n;
         out_vld  <= state_has_main(st_n);
         skid_vld <= state_has_skid(st_n);
         in_rdy   <= state_can_accept(st_n);
      end
   end

   assign occ = st_q;

   nv_pipe_reg_x #(
      .DW       (DW),
      .RESET_PD (RESET_PD)
   ) u_main (
      .clk   (clk),
      .reset (reset),
      .en    (main_en),
      .d     (main_d),
      .q     (out_pd)
   );

   nv_pipe_reg_x #(
      .DW       (DW),
      .RESET_PD (RESET_PD)
   ) u_skid (
      .clk   (clk),
      .reset (reset),
      .en    (skid_en),
      .d     (in_pd),
      .q     (skid_pd)
   );

endmodule
